// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised image-display controller.
// Loads an IMG_W x IMG_H frame serially into an internal buffer, then streams a
// WIN x WIN view of it after every accepted command. Fit mode subsamples the whole
// frame; zoom mode shows a movable window. Horizontal/vertical mirroring persists.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   datain       pixel stream during LOAD, raster order
//   cmd          command code (0..9 legal)
//   cmd_valid    command strobe
//   dataout      displayed pixel (holds between displays)
//   output_valid dataout qualifier
//   busy         high while a command executes; commands are refused while high
module lcd_ctrl_param #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned NWIN = WIN * WIN;
    localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    // Counter covers both the load sweep (NPIX-1) and the display end marker (NWIN).
    localparam int unsigned CW   = $clog2(NPIX + 1);
    localparam int unsigned XW   = $clog2(IMG_W + 1);
    localparam int unsigned YW   = $clog2(IMG_H + 1);

    localparam logic [XW-1:0] OX0  = XW'((IMG_W - WIN) / 2);
    localparam logic [YW-1:0] OY0  = YW'((IMG_H - WIN) / 2);
    localparam logic [XW-1:0] XMAX = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] YMAX = YW'(IMG_H - WIN);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StDisp} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cmd_q, cmd_d;
    logic            zoom_q, zoom_d;
    logic [XW-1:0]   ox_q, ox_d;
    logic [YW-1:0]   oy_q, oy_d;
    logic            mir_h_q, mir_h_d;
    logic            mir_v_q, mir_v_d;
    logic [DW-1:0]   dataout_d;
    logic            valid_d;
    logic            mem_we;
    logic [AW-1:0]   pix_addr;

    logic [DW-1:0]   mem [NPIX];

    assign busy = (state_q != StIdle);

    // Buffer address of window position cnt_q, after mirroring.
    always_comb begin
        int unsigned k, r, c, rr, cc, a;
        k  = 32'(cnt_q);
        r  = k / WIN;
        c  = k % WIN;
        cc = mir_h_q ? (WIN - 1 - c) : c;
        rr = mir_v_q ? (WIN - 1 - r) : r;
        if (zoom_q) begin
            a = (32'(oy_q) + rr) * IMG_W + 32'(ox_q) + cc;
        end else begin
            a = rr * (IMG_H / WIN) * IMG_W + cc * (IMG_W / WIN);
        end
        pix_addr = AW'(a);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        zoom_d    = zoom_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        mir_h_d   = mir_h_q;
        mir_v_d   = mir_v_q;
        dataout_d = dataout;
        valid_d   = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid && (cmd <= 4'd9)) begin
                    cmd_d   = cmd;
                    cnt_d   = '0;
                    state_d = (cmd == 4'd1) ? StLoad : StExec;
                end
            end
            StLoad: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NPIX - 1)) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StDisp;
                cnt_d   = '0;
                case (cmd_q)
                    4'd1: begin
                        zoom_d  = 1'b0;
                        ox_d    = OX0;
                        oy_d    = OY0;
                        mir_h_d = 1'b0;
                        mir_v_d = 1'b0;
                    end
                    4'd2: begin
                        zoom_d = 1'b1;
                        ox_d   = OX0;
                        oy_d   = OY0;
                    end
                    4'd3: zoom_d = 1'b0;
                    4'd4: if (zoom_q && (ox_q < XMAX)) ox_d = ox_q + XW'(1);
                    4'd5: if (zoom_q && (ox_q != '0)) ox_d = ox_q - XW'(1);
                    4'd6: if (zoom_q && (oy_q != '0)) oy_d = oy_q - YW'(1);
                    4'd7: if (zoom_q && (oy_q < YMAX)) oy_d = oy_q + YW'(1);
                    4'd8: mir_h_d = ~mir_h_q;
                    4'd9: mir_v_d = ~mir_v_q;
                    default: ;
                endcase
            end
            StDisp: begin
                // One extra cycle after the last pixel drops valid and busy together.
                if (cnt_q == CW'(NWIN)) begin
                    state_d = StIdle;
                end else begin
                    dataout_d = mem[pix_addr];
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cmd_q        <= '0;
            zoom_q       <= 1'b0;
            ox_q         <= OX0;
            oy_q         <= OY0;
            mir_h_q      <= 1'b0;
            mir_v_q      <= 1'b0;
            dataout      <= '0;
            output_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            zoom_q       <= zoom_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            mir_h_q      <= mir_h_d;
            mir_v_q      <= mir_v_d;
            dataout      <= dataout_d;
            output_valid <= valid_d;
        end
    end

    // Frame buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cnt_q[AW-1:0]] <= datain;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: scoreboard bench for lcd_ctrl_param (8x8 frame, 4x4 window).
// Expected pixels are queued when a command is driven and popped by a monitor
// whenever output_valid is seen.
module tb_lcd_ctrl_param;

    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int WIN   = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = WIN * WIN;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] datain;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    lcd_ctrl_param #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int out_cnt = 0;
    int exp_q[$];

    // Reference model state
    int  tb_mem [NPIX];
    int  ld [NPIX];
    bit  m_zoom;
    int  m_ox, m_oy;
    bit  m_mh, m_mv;

    int busy_cycles;
    int first_valid;

    const int load_exp [16] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54};
    const int zoom_exp [16] = '{18, 19, 20, 21, 26, 27, 28, 29, 34, 35, 36, 37, 42, 43, 44, 45};

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (output_valid) begin
            int e;
            out_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: got %0d, required no output", dataout);
            end else begin
                e = exp_q.pop_front();
                if (int'(dataout) !== e) begin
                    n_bad++;
                    $display("FAIL pixel #%0d: got %0d, required %0d", out_cnt, dataout, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_pix(input int k);
        int r, c, rr, cc;
        r  = k / WIN;
        c  = k % WIN;
        cc = m_mh ? WIN - 1 - c : c;
        rr = m_mv ? WIN - 1 - r : r;
        if (m_zoom) return tb_mem[(m_oy + rr) * IMG_W + m_ox + cc];
        return tb_mem[(rr * IMG_H / WIN) * IMG_W + cc * IMG_W / WIN];
    endfunction

    task automatic model_reset();
        m_zoom = 0;
        m_ox   = (IMG_W - WIN) / 2;
        m_oy   = (IMG_H - WIN) / 2;
        m_mh   = 0;
        m_mv   = 0;
    endtask

    task automatic model_apply(input int c);
        case (c)
            1: begin
                model_reset();
                for (int i = 0; i < NPIX; i++) tb_mem[i] = ld[i];
            end
            2: begin
                m_zoom = 1;
                m_ox   = (IMG_W - WIN) / 2;
                m_oy   = (IMG_H - WIN) / 2;
            end
            3: m_zoom = 0;
            4: if (m_zoom && m_ox < IMG_W - WIN) m_ox++;
            5: if (m_zoom && m_ox > 0) m_ox--;
            6: if (m_zoom && m_oy > 0) m_oy--;
            7: if (m_zoom && m_oy < IMG_H - WIN) m_oy++;
            8: m_mh = !m_mh;
            9: m_mv = !m_mv;
            default: ;
        endcase
    endtask

    // Drive one command, streaming the frame for LOAD, and wait for completion.
    task automatic send_cmd(input logic [3:0] c, input bit push_model);
        int n;
        model_apply(int'(c));
        if (push_model) begin
            for (int k = 0; k < NWIN; k++) exp_q.push_back(exp_pix(k));
        end
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        n           = 1;
        busy_cycles = 0;
        first_valid = -1;
        if (c == 4'd1) begin
            datain = DW'(ld[0]);
            for (int i = 1; i < NPIX; i++) begin
                @(negedge clk);
                n++;
                datain = DW'(ld[i]);
            end
        end
        for (int t = 0; t < 300; t++) begin
            if (busy) busy_cycles++;
            if (output_valid && first_valid < 0) first_valid = n;
            if (!busy) break;
            @(negedge clk);
            n++;
            if (t == 299) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cmd_timeout: cmd %0d busy still 1, required 0", c);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b, required 0", output_valid);
        end
        n_cmp++;
        if (dataout !== '0) begin
            n_bad++;
            $display("FAIL reset_dataout: got %0d, required 0", dataout);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < NPIX; i++) ld[i] = i;
        for (int k = 0; k < NWIN; k++) exp_q.push_back(load_exp[k]);
        send_cmd(4'd1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL load_busy_after: got %b, required 0", busy);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_valid_after: got %b, required 0", output_valid);
        end
    endtask

    task automatic test_zoom_in();
        for (int k = 0; k < NWIN; k++) exp_q.push_back(zoom_exp[k]);
        send_cmd(4'd2, 1'b0);
        n_cmp++;
        if (busy_cycles != NWIN + 2) begin
            n_bad++;
            $display("FAIL zoom_busy_cycles: got %0d, required %0d", busy_cycles, NWIN + 2);
        end
        n_cmp++;
        if (first_valid != 3) begin
            n_bad++;
            $display("FAIL zoom_first_pixel_latency: got %0d, required 3", first_valid);
        end
    endtask

    task automatic test_pan();
        repeat (3) send_cmd(4'd4, 1'b1);
        repeat (3) send_cmd(4'd6, 1'b1);
        // Last shown pixel (origin (4,0), position 15) must be held afterwards.
        repeat (3) @(negedge clk);
        n_cmp++;
        if (int'(dataout) !== 31) begin
            n_bad++;
            $display("FAIL dataout_hold: got %0d, required 31", dataout);
        end
    endtask

    task automatic test_mirror();
        send_cmd(4'd2, 1'b1);
        send_cmd(4'd8, 1'b1);
        send_cmd(4'd3, 1'b1);
        send_cmd(4'd9, 1'b1);
    endtask

    task automatic test_illegal();
        int c0;
        @(negedge clk);
        c0        = out_cnt;
        cmd       = 4'd12;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_busy[%0d]: got %b, required 0", i, busy);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_cnt != c0) begin
            n_bad++;
            $display("FAIL illegal_outputs: got %0d, required 0", out_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = out_cnt;
        model_apply(0);
        for (int k = 0; k < NWIN; k++) exp_q.push_back(exp_pix(k));
        @(negedge clk);
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd = 4'd2;  // held strobe with a view-changing command must be ignored
        for (int t = 0; t < 100; t++) begin
            if (!busy) break;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_cnt - c0 != NWIN) begin
            n_bad++;
            $display("FAIL overlap_count: got %0d, required %0d", out_cnt - c0, NWIN);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL overlap_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_fit_right();
        send_cmd(4'd4, 1'b1);
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        cmd       = 4'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        datain    = 8'd100;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            datain = DW'(100 + i);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midload_reset_busy: got %b, required 0", busy);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midload_reset_valid: got %b, required 0", output_valid);
        end
        n_cmp++;
        if (dataout !== '0) begin
            n_bad++;
            $display("FAIL midload_reset_dataout: got %0d, required 0", dataout);
        end
        for (int i = 0; i < NPIX; i++) ld[i] = i;
        for (int k = 0; k < NWIN; k++) exp_q.push_back(load_exp[k]);
        send_cmd(4'd1, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        datain    = '0;
        cmd       = '0;
        cmd_valid = 1'b0;
        for (int i = 0; i < NPIX; i++) tb_mem[i] = 0;
        test_reset();
        test_load();
        test_zoom_in();
        test_pan();
        test_mirror();
        test_illegal();
        test_back_to_back();
        test_fit_right();
        test_reset_midload();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_pixels: got %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
